// File: rtl/bip_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bip_run_ctrl_if
// Brief    : Report/TX snapshot handshake between the run controller and the
//            report consumer (valid/ready with {pc, acc, cycles} payload).
// Revision : 1.0
// ============================================================================
interface bip_run_ctrl_if #(
    parameter int PC_BITS  = 11,
    parameter int ACC_BITS = 16,
    parameter int CNT_BITS = 16
);
    localparam int c_DATA_W = PC_BITS + ACC_BITS + CNT_BITS;

    logic                o_ReportValid;
    logic                i_ReportReady;
    logic [c_DATA_W-1:0] o_ReportData;

    modport master (
        output o_ReportValid,
        output o_ReportData,
        input  i_ReportReady
    );

    modport slave (
        input  o_ReportValid,
        input  o_ReportData,
        output i_ReportReady
    );
endinterface
`default_nettype wire

// File: rtl/bip_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bip_run_ctrl
// Brief    : BIP CPU execution sequencer: clear, RUN/STEP gating via clock
//            enable, HLT detection, instruction counting and snapshot report.
// Revision : 1.0
// ============================================================================
module bip_run_ctrl #(
    parameter int OPCODE   = 5,
    parameter int PC_BITS  = 11,
    parameter int ACC_BITS = 16,
    parameter int CNT_BITS = 16
) (
    input  wire logic                i_clock,
    input  wire logic                i_reset,
    input  wire logic                i_Start,
    input  wire logic                i_Step,
    input  wire logic [OPCODE-1:0]   i_Opcode,
    input  wire logic [PC_BITS-1:0]  i_Pc,
    input  wire logic [ACC_BITS-1:0] i_Acc,
    bip_run_ctrl_if.master           rpt_if,
    output logic                     o_CpuEn,
    output logic                     o_CpuClr,
    output logic [CNT_BITS-1:0]      o_Cycles,
    output logic                     o_Halted,
    output logic                     o_Busy
);
    localparam int c_DATA_W = PC_BITS + ACC_BITS + CNT_BITS;

    localparam logic [OPCODE-1:0]   c_HLT       = '0;
    localparam logic [CNT_BITS-1:0] c_CNT_MAX   = '1;
    localparam logic [CNT_BITS-1:0] c_CNT_ONE   = {{(CNT_BITS-1){1'b0}}, 1'b1};

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_CLR       = 3'd1;
    localparam logic [2:0] c_S_RUN       = 3'd2;
    localparam logic [2:0] c_S_STEP_WAIT = 3'd3;
    localparam logic [2:0] c_S_STEP_EXEC = 3'd4;
    localparam logic [2:0] c_S_REPORT    = 3'd5;
    localparam logic [2:0] c_S_DONE      = 3'd6;

    logic [2:0]          r_state;
    logic                r_start_q;
    logic                r_step_q;
    logic                r_mode_step;
    logic                r_final;
    logic                r_snap_pend;
    logic [CNT_BITS-1:0] r_cycles;
    logic [c_DATA_W-1:0] r_snap;

    logic [2:0]          w_state_nxt;
    logic                w_start_p;
    logic                w_step_p;
    logic                w_is_hlt;
    logic                w_cpu_en;
    logic                w_rpt_valid;
    logic                w_rpt_fire;
    logic                w_hlt_seen;
    logic                w_snap_now;

    assign w_start_p = i_Start & ~r_start_q;
    assign w_step_p  = i_Step  & ~r_step_q;
    assign w_is_hlt  = (i_Opcode == c_HLT);

    // STEP_EXEC never runs on HLT: STEP_WAIT diverts to REPORT first.
    assign w_cpu_en  = ((r_state == c_S_RUN) && !w_is_hlt) ||
                       (r_state == c_S_STEP_EXEC);

    // After a step the snapshot loads in the first REPORT cycle, so valid
    // is held back one cycle to present post-instruction PC/ACC.
    assign w_rpt_valid = (r_state == c_S_REPORT) && !r_snap_pend;
    assign w_rpt_fire  = w_rpt_valid && rpt_if.i_ReportReady;

    assign w_hlt_seen  = ((r_state == c_S_RUN) || (r_state == c_S_STEP_WAIT)) && w_is_hlt;
    assign w_snap_now  = w_hlt_seen || ((r_state == c_S_REPORT) && r_snap_pend);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_start_p || w_step_p) begin
                    w_state_nxt = c_S_CLR;
                end
            end
            c_S_CLR: begin
                w_state_nxt = r_mode_step ? c_S_STEP_WAIT : c_S_RUN;
            end
            c_S_RUN: begin
                if (w_is_hlt) begin
                    w_state_nxt = c_S_REPORT;
                end
            end
            c_S_STEP_WAIT: begin
                if (w_is_hlt) begin
                    w_state_nxt = c_S_REPORT;
                end else if (w_start_p) begin
                    w_state_nxt = c_S_RUN;
                end else if (w_step_p) begin
                    w_state_nxt = c_S_STEP_EXEC;
                end
            end
            c_S_STEP_EXEC: begin
                w_state_nxt = c_S_REPORT;
            end
            c_S_REPORT: begin
                if (w_rpt_fire) begin
                    w_state_nxt = r_final ? c_S_DONE : c_S_STEP_WAIT;
                end
            end
            c_S_DONE: begin
                if (w_start_p || w_step_p) begin
                    w_state_nxt = c_S_CLR;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= c_S_IDLE;
            r_start_q   <= 1'b0;
            r_step_q    <= 1'b0;
            r_mode_step <= 1'b0;
            r_final     <= 1'b0;
            r_snap_pend <= 1'b0;
            r_cycles    <= '0;
            r_snap      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_start_q   <= i_Start;
            r_step_q    <= i_Step;
            r_snap_pend <= (r_state == c_S_STEP_EXEC);

            // Start has priority over step when both rise together.
            if ((r_state == c_S_IDLE) || (r_state == c_S_DONE)) begin
                if (w_start_p) begin
                    r_mode_step <= 1'b0;
                end else if (w_step_p) begin
                    r_mode_step <= 1'b1;
                end
            end

            if (r_state == c_S_CLR) begin
                r_cycles <= '0;
                r_final  <= 1'b0;
            end else begin
                if (w_cpu_en && (r_cycles != c_CNT_MAX)) begin
                    r_cycles <= r_cycles + c_CNT_ONE;
                end
                if (w_hlt_seen) begin
                    r_final <= 1'b1;
                end
            end

            if (w_snap_now) begin
                r_snap <= {i_Pc, i_Acc, r_cycles};
            end
        end
    end

    assign o_CpuEn              = w_cpu_en;
    assign o_CpuClr             = (r_state == c_S_CLR);
    assign o_Cycles             = r_cycles;
    assign o_Halted             = (r_state == c_S_DONE);
    assign o_Busy               = (r_state != c_S_IDLE) && (r_state != c_S_DONE) &&
                                  (r_state != 3'd7);
    assign rpt_if.o_ReportValid = w_rpt_valid;
    assign rpt_if.o_ReportData  = r_snap;

endmodule
`default_nettype wire
